mem_access_ctrl: RTL and testbench

- Sequences the data-memory access for the instruction held in the EX/MEM pipeline register.
- Decodes the registered memory-op fields into a valid/ready request on the data-memory bus, and waits for the response.
- Aligns and sign/zero-extends load data.
- Holds `mem_stall` high so the EX/MEM register and all earlier stages freeze until the access completes.

---
 rtl/mem_access_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: data-memory access sequencer for the EX/MEM stage.
// Decodes the held memory op into a valid/ready bus request and waits
// for the response. It aligns and extends load data, and holds
// mem_stall until the access is retired.
module mem_access_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MEM_mem_ena,
    input  logic              MEM_mem_wr,
    input  logic [2:0]        MEM_memwop,
    input  logic [2:0]        MEM_memrop,
    input  logic [ADDR_W-1:0] MEM_mem_addr,
    input  logic [DATA_W-1:0] MEM_mem_stor_data,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_wr,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [7:0]        dmem_wmask,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             is_load_r;
    logic [2:0]       rop_r;
    logic [2:0]       off_r;

    logic             acc_s;
    logic             mis_s;
    logic             start_s;
    logic [1:0]       size_s;   // 0 byte, 1 half, 2 word, 3 double
    logic [7:0]       lane_s;
    logic [7:0]       wmask_s;
    logic [DATA_W-1:0] wdata_s;
    logic [2:0]       off_s;

    // Shift the doubleword right to the accessed byte, then extend per load op.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] rdata,
        input logic [2:0]        off,
        input logic [2:0]        rop
    );
        logic [DATA_W-1:0] raw;
        raw = rdata >> {off, 3'b000};
        case (rop)
            3'd1:    load_extract = {{56{raw[7]}}, raw[7:0]};
            3'd2:    load_extract = {{48{raw[15]}}, raw[15:0]};
            3'd3:    load_extract = {{32{raw[31]}}, raw[31:0]};
            3'd5:    load_extract = {56'h0, raw[7:0]};
            3'd6:    load_extract = {48'h0, raw[15:0]};
            3'd7:    load_extract = {32'h0, raw[31:0]};
            default: load_extract = raw;
        endcase
    endfunction

    // Decode access validity, size, alignment and store byte lanes from the held op.
    always_comb begin
        off_s  = MEM_mem_addr[2:0];
        acc_s  = 1'b0;
        size_s = 2'd0;
        if (MEM_mem_wr) begin
            acc_s = MEM_mem_ena & (MEM_memwop >= 3'd1) & (MEM_memwop <= 3'd4);
            case (MEM_memwop)
                3'd2:    size_s = 2'd1;
                3'd3:    size_s = 2'd2;
                3'd4:    size_s = 2'd3;
                default: size_s = 2'd0;
            endcase
        end else begin
            acc_s = MEM_mem_ena & (MEM_memrop != 3'd0);
            case (MEM_memrop)
                3'd2, 3'd6: size_s = 2'd1;
                3'd3, 3'd7: size_s = 2'd2;
                3'd4:       size_s = 2'd3;
                default:    size_s = 2'd0;
            endcase
        end
        case (size_s)
            2'd1:    begin mis_s = off_s[0];              lane_s = 8'h03; end
            2'd2:    begin mis_s = (off_s[1:0] != 2'd0);  lane_s = 8'h0F; end
            2'd3:    begin mis_s = (off_s != 3'd0);       lane_s = 8'hFF; end
            default: begin mis_s = 1'b0;                  lane_s = 8'h01; end
        endcase
        if (MEM_mem_wr) begin
            wmask_s = lane_s << off_s;
            wdata_s = MEM_mem_stor_data << {off_s, 3'b000};
        end else begin
            wmask_s = 8'h00;
            wdata_s = '0;
        end
        start_s = (state_r == ST_IDLE) & acc_s & ~mis_s;
    end

    // Stall the pipeline from the detect cycle until the access reaches DONE.
    always_comb begin
        case (state_r)
            ST_IDLE: mem_stall = start_s;
            ST_REQ:  mem_stall = 1'b1;
            ST_WAIT: mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    // Access sequencer with registered bus, result and error outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            is_load_r      <= 1'b0;
            rop_r          <= 3'd0;
            off_r          <= 3'd0;
            dmem_req_valid <= 1'b0;
            dmem_wr        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wmask     <= 8'h00;
            load_valid     <= 1'b0;
            load_data      <= '0;
            misalign_err   <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (acc_s && mis_s) begin
                        misalign_err <= 1'b1;
                    end else if (acc_s) begin
                        state_r        <= ST_REQ;
                        dmem_req_valid <= 1'b1;
                        dmem_wr        <= MEM_mem_wr;
                        dmem_addr      <= {MEM_mem_addr[ADDR_W-1:3], 3'b000};
                        dmem_wdata     <= wdata_s;
                        dmem_wmask     <= wmask_s;
                        is_load_r      <= ~MEM_mem_wr;
                        rop_r          <= MEM_memrop;
                        off_r          <= off_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        cnt_r          <= '0;
                        state_r        <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rsp_valid) begin
                        state_r    <= ST_DONE;
                        load_valid <= is_load_r;
                        if (is_load_r) begin
                            load_data <= load_extract(dmem_rdata, off_r, rop_r);
                        end else begin
                            load_data <= load_data;
                        end
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        state_r    <= ST_DONE;
                        bus_err    <= 1'b1;
                        load_valid <= is_load_r;
                        load_data  <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a default-timeout instance (a) and a
// TIMEOUT=4 instance (b) share every input; outputs are sampled on negedges.
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        MEM_mem_ena;
    logic        MEM_mem_wr;
    logic [2:0]  MEM_memwop;
    logic [2:0]  MEM_memrop;
    logic [63:0] MEM_mem_addr;
    logic [63:0] MEM_mem_stor_data;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rdata;

    logic        req_valid_a, wr_a, stall_a, load_valid_a, mis_a, bus_err_a;
    logic [63:0] addr_a, wdata_a, load_data_a;
    logic [7:0]  wmask_a;
    logic        req_valid_b, wr_b, stall_b, load_valid_b, mis_b, bus_err_b;
    logic [63:0] addr_b, wdata_b, load_data_b;
    logic [7:0]  wmask_b;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clock = ~clock;

    mem_access_ctrl dut_a (
        .clock(clock), .reset(reset),
        .MEM_mem_ena(MEM_mem_ena), .MEM_mem_wr(MEM_mem_wr),
        .MEM_memwop(MEM_memwop), .MEM_memrop(MEM_memrop),
        .MEM_mem_addr(MEM_mem_addr), .MEM_mem_stor_data(MEM_mem_stor_data),
        .dmem_req_valid(req_valid_a), .dmem_req_ready(dmem_req_ready),
        .dmem_wr(wr_a), .dmem_addr(addr_a), .dmem_wdata(wdata_a),
        .dmem_wmask(wmask_a), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .mem_stall(stall_a),
        .load_valid(load_valid_a), .load_data(load_data_a),
        .misalign_err(mis_a), .bus_err(bus_err_a)
    );

    mem_access_ctrl #(.TIMEOUT(4)) dut_b (
        .clock(clock), .reset(reset),
        .MEM_mem_ena(MEM_mem_ena), .MEM_mem_wr(MEM_mem_wr),
        .MEM_memwop(MEM_memwop), .MEM_memrop(MEM_memrop),
        .MEM_mem_addr(MEM_mem_addr), .MEM_mem_stor_data(MEM_mem_stor_data),
        .dmem_req_valid(req_valid_b), .dmem_req_ready(dmem_req_ready),
        .dmem_wr(wr_b), .dmem_addr(addr_b), .dmem_wdata(wdata_b),
        .dmem_wmask(wmask_b), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .mem_stall(stall_b),
        .load_valid(load_valid_b), .load_data(load_data_b),
        .misalign_err(mis_b), .bus_err(bus_err_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        MEM_mem_ena = 1'b0; MEM_mem_wr = 1'b0; MEM_memwop = 3'd0; MEM_memrop = 3'd0;
        MEM_mem_addr = 64'h0; MEM_mem_stor_data = 64'h0;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 64'h0;
        #12;
        chk("rst_req_valid", {63'h0, req_valid_a}, 64'h0);
        chk("rst_stall", {63'h0, stall_a}, 64'h0);
        chk("rst_addr", addr_a, 64'h0);
        chk("rst_load_data", load_data_a, 64'h0);
        chk("rst_wmask", {56'h0, wmask_a}, 64'h0);
        smp();
        reset = 1'b1;

        // LB at 0x8000_0003, ready and response immediate
        drv(); MEM_mem_ena = 1'b1; MEM_memrop = 3'd1; MEM_mem_addr = 64'h8000_0003;
        smp(); chk("lb_t_stall", {63'h0, stall_a}, 64'h1);
        chk("lb_t_req_valid", {63'h0, req_valid_a}, 64'h0);
        drv(); MEM_mem_ena = 1'b0; MEM_memrop = 3'd0; MEM_mem_addr = 64'h0;
        smp(); chk("lb_req_valid", {63'h0, req_valid_a}, 64'h1);
        chk("lb_addr", addr_a, 64'h8000_0000);
        chk("lb_wmask", {56'h0, wmask_a}, 64'h0);
        chk("lb_wr", {63'h0, wr_a}, 64'h0);
        chk("lb_req_stall", {63'h0, stall_a}, 64'h1);
        drv(); dmem_rsp_valid = 1'b1; dmem_rdata = 64'h0000_0000_8000_0000;
        smp(); chk("lb_wait_req_valid", {63'h0, req_valid_a}, 64'h0);
        chk("lb_wait_stall", {63'h0, stall_a}, 64'h1);
        drv(); dmem_rsp_valid = 1'b0;
        smp(); chk("lb_done_load_valid", {63'h0, load_valid_a}, 64'h1);
        chk("lb_load_data", load_data_a, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_done_stall", {63'h0, stall_a}, 64'h0);
        chk("lb_b_load_data", load_data_b, 64'hFFFF_FFFF_FFFF_FF80);
        drv();
        smp(); chk("lb_idle_load_valid", {63'h0, load_valid_a}, 64'h0);
        chk("lb_idle_stall", {63'h0, stall_a}, 64'h0);

        // LD with no response: instance b (TIMEOUT=4) aborts with bus_err
        drv(); MEM_mem_ena = 1'b1; MEM_memrop = 3'd4; MEM_mem_addr = 64'h2000;
        smp(); chk("to_t_stall", {63'h0, stall_b}, 64'h1);
        drv(); MEM_mem_ena = 1'b0; MEM_memrop = 3'd0;
        smp();
        n = 0;
        while (bus_err_b !== 1'b1 && n < 20) begin
            chk("to_wait_stall", {63'h0, stall_b}, 64'h1);
            drv(); smp();
            n++;
        end
        chk("to_bus_err", {63'h0, bus_err_b}, 64'h1);
        chk("to_latency", 64'(n), 64'd5);
        chk("to_load_data", load_data_b, 64'h0);
        chk("to_done_stall", {63'h0, stall_b}, 64'h0);
        chk("to_a_still_waiting", {63'h0, stall_a}, 64'h1);
        drv();
        smp(); chk("to_bus_err_pulse", {63'h0, bus_err_b}, 64'h0);
        chk("to_idle_stall", {63'h0, stall_b}, 64'h0);
        drv(); dmem_rsp_valid = 1'b1; dmem_rdata = 64'h1122_3344_5566_7788;
        smp();
        drv(); dmem_rsp_valid = 1'b0;
        smp(); chk("ld_a_load_valid", {63'h0, load_valid_a}, 64'h1);
        chk("ld_a_load_data", load_data_a, 64'h1122_3344_5566_7788);
        chk("late_rsp_b_ignored", {63'h0, load_valid_b}, 64'h0);
        drv(); smp();

        // SH at 0x1006 with ready held low for 4 cycles
        drv(); MEM_mem_ena = 1'b1; MEM_mem_wr = 1'b1; MEM_memwop = 3'd2;
        MEM_mem_addr = 64'h1006; MEM_mem_stor_data = 64'hABCD; dmem_req_ready = 1'b0;
        smp(); chk("sh_t_stall", {63'h0, stall_a}, 64'h1);
        drv(); MEM_mem_ena = 1'b0; MEM_mem_wr = 1'b0; MEM_memwop = 3'd0;
        MEM_mem_addr = 64'h0; MEM_mem_stor_data = 64'h0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("sh_req_valid", {63'h0, req_valid_a}, 64'h1);
            chk("sh_wr", {63'h0, wr_a}, 64'h1);
            chk("sh_addr", addr_a, 64'h1000);
            chk("sh_wmask", {56'h0, wmask_a}, 64'hC0);
            chk("sh_wdata", wdata_a, 64'hABCD_0000_0000_0000);
            chk("sh_stall", {63'h0, stall_a}, 64'h1);
            drv();
        end
        dmem_req_ready = 1'b1;
        smp(); chk("sh_req_valid_5", {63'h0, req_valid_a}, 64'h1);
        drv(); dmem_rsp_valid = 1'b1;
        smp(); chk("sh_wait_req_valid", {63'h0, req_valid_a}, 64'h0);
        chk("sh_wait_stall", {63'h0, stall_a}, 64'h1);
        drv(); dmem_rsp_valid = 1'b0;
        smp(); chk("sh_no_load_valid", {63'h0, load_valid_a}, 64'h0);
        chk("sh_done_stall", {63'h0, stall_a}, 64'h0);
        drv(); smp();

        // LW at 0x1002 is misaligned
        drv(); MEM_mem_ena = 1'b1; MEM_memrop = 3'd3; MEM_mem_addr = 64'h1002;
        smp(); chk("lw_mis_t_stall", {63'h0, stall_a}, 64'h0);
        chk("lw_mis_t_req", {63'h0, req_valid_a}, 64'h0);
        drv(); MEM_mem_ena = 1'b0; MEM_memrop = 3'd0;
        smp(); chk("lw_mis_err", {63'h0, mis_a}, 64'h1);
        chk("lw_mis_req", {63'h0, req_valid_a}, 64'h0);
        chk("lw_mis_stall", {63'h0, stall_a}, 64'h0);
        drv();
        smp(); chk("lw_mis_err_pulse", {63'h0, mis_a}, 64'h0);
        chk("lw_mis_req2", {63'h0, req_valid_a}, 64'h0);

        // LWU at 0x1004, response after 5 WAIT cycles
        drv(); MEM_mem_ena = 1'b1; MEM_memrop = 3'd7; MEM_mem_addr = 64'h1004;
        smp(); chk("lwu_t_stall", {63'h0, stall_a}, 64'h1);
        drv(); MEM_mem_ena = 1'b0; MEM_memrop = 3'd0;
        smp(); chk("lwu_req_valid", {63'h0, req_valid_a}, 64'h1);
        chk("lwu_addr", addr_a, 64'h1000);
        for (int i = 0; i < 5; i++) begin
            drv();
            smp(); chk("lwu_wait_stall", {63'h0, stall_a}, 64'h1);
        end
        drv(); dmem_rsp_valid = 1'b1; dmem_rdata = 64'hF000_0001_0000_0000;
        smp(); chk("lwu_rsp_stall", {63'h0, stall_a}, 64'h1);
        drv(); dmem_rsp_valid = 1'b0;
        smp(); chk("lwu_load_valid", {63'h0, load_valid_a}, 64'h1);
        chk("lwu_load_data", load_data_a, 64'h0000_0000_F000_0001);
        chk("lwu_done_stall", {63'h0, stall_a}, 64'h0);
        drv(); smp();

        // Reset during WAIT, then a late response
        drv(); MEM_mem_ena = 1'b1; MEM_memrop = 3'd4; MEM_mem_addr = 64'h3000;
        smp();
        drv(); MEM_mem_ena = 1'b0; MEM_memrop = 3'd0; MEM_mem_addr = 64'h0;
        smp();
        drv();
        smp(); chk("rw_wait_stall", {63'h0, stall_a}, 64'h1);
        drv(); reset = 1'b0;
        #1;
        chk("rw_req_valid", {63'h0, req_valid_a}, 64'h0);
        chk("rw_stall", {63'h0, stall_a}, 64'h0);
        chk("rw_addr", addr_a, 64'h0);
        chk("rw_load_data", load_data_a, 64'h0);
        chk("rw_load_valid", {63'h0, load_valid_a}, 64'h0);
        smp(); reset = 1'b1;
        drv(); dmem_rsp_valid = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        smp(); chk("rw_late_stall", {63'h0, stall_a}, 64'h0);
        drv(); dmem_rsp_valid = 1'b0;
        smp(); chk("rw_late_load_valid", {63'h0, load_valid_a}, 64'h0);
        chk("rw_late_load_data", load_data_a, 64'h0);
        chk("rw_late_req_valid", {63'h0, req_valid_a}, 64'h0);
        chk("rw_late_stall2", {63'h0, stall_a}, 64'h0);
        drv();
        smp(); chk("rw_late_load_valid2", {63'h0, load_valid_a}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
